array_ram_dumper: RTL and testbench

//  Hardware read-out engine for the SoC array RAM: on a start pulse, reads words

---
 rtl/array_ram_dumper.sv | 163 ++++++++++++++++
 tb/tb_array_ram_dumper.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/array_ram_dumper.sv
// -----------------------------------------------------------------------------
// array_ram_dumper
//
// Read-out engine for the array RAM. A one-cycle start pulse latches an
// inclusive word range [cfg_first, cfg_last]. Each word in the range is then
// read through a RAM port with one cycle of read latency and streamed out as
// one beat on a valid/ready interface. Each beat carries the data word, its
// address, and a flag that marks the final address of the range.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start, abort           dump request (samples cfg_*), cancel in progress
//   cfg_first, cfg_last    inclusive word range to dump
//   ram_re, ram_addr       RAM read request; ram_rdata valid the next cycle
//   ram_rdata              RAM read data
//   m_valid, m_ready       output stream handshake
//   m_data, m_addr, m_last beat payload
//   busy                   high whenever the engine is not idle
//   done, err              one-cycle end-of-dump pulse, err for an empty range
//   dbg_state              current FSM state
//
// Handshake: a beat transfers on a rising edge where m_valid and m_ready are
// both high. While m_valid is high and m_ready is low, m_data, m_addr and
// m_last stay stable. m_valid never depends combinationally on m_ready.
// -----------------------------------------------------------------------------
module array_ram_dumper #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_first,
    input  logic [ADDR_W-1:0] cfg_last,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_OUT  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_q;
    logic              err_flag_q;
    logic              ram_re_q;
    logic              m_valid_q;
    logic [DATA_W-1:0] m_data_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic              m_last_q;
    logic              done_q;
    logic              err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            err_flag_q <= 1'b0;
            ram_re_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_addr_q   <= '0;
            m_last_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // done/err are single-cycle pulses raised only on entry to FIN.
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (abort && state_q != ST_IDLE) begin
                // Abort overrides every transition: drop the beat in flight
                // and any pending read, and end without a done pulse.
                state_q    <= ST_IDLE;
                ram_re_q   <= 1'b0;
                m_valid_q  <= 1'b0;
                err_flag_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // An abort in the same cycle drops the request.
                        if (start && !abort) begin
                            last_q <= cfg_last;
                            if (cfg_first > cfg_last) begin
                                err_flag_q <= 1'b1;
                                done_q     <= 1'b1;
                                err_q      <= 1'b1;
                                state_q    <= ST_FIN;
                            end else begin
                                addr_q   <= cfg_first;
                                ram_re_q <= 1'b1;
                                state_q  <= ST_RD;
                            end
                        end
                    end
                    ST_RD: begin
                        ram_re_q <= 1'b0;
                        state_q  <= ST_CAP;
                    end
                    ST_CAP: begin
                        m_data_q  <= ram_rdata;
                        m_addr_q  <= addr_q;
                        m_last_q  <= (addr_q == last_q);
                        m_valid_q <= 1'b1;
                        state_q   <= ST_OUT;
                    end
                    ST_OUT: begin
                        if (m_ready) begin
                            m_valid_q <= 1'b0;
                            // The last flag was resolved before any increment,
                            // so a range ending at the top address never wraps.
                            if (m_last_q) begin
                                done_q  <= 1'b1;
                                err_q   <= err_flag_q;
                                state_q <= ST_FIN;
                            end else begin
                                addr_q   <= addr_q + 1'b1;
                                ram_re_q <= 1'b1;
                                state_q  <= ST_RD;
                            end
                        end
                    end
                    ST_FIN: begin
                        err_flag_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ram_re    = ram_re_q;
    assign ram_addr  = addr_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_addr    = m_addr_q;
    assign m_last    = m_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_array_ram_dumper.sv
// -----------------------------------------------------------------------------
// Testbench for array_ram_dumper. The RAM holds RAM[i] = 3*i. The expected
// beat stream for a range is {addr==last, addr, 3*addr} for each address from
// first to last, in order. A monitor compares every accepted beat, every done
// pulse, and payload stability during stalls. Directed literal checks cover
// the start-to-output latency, the error path, abort and reset.
// -----------------------------------------------------------------------------
module tb_array_ram_dumper;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int BW     = ADDR_W + DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort;
    logic [ADDR_W-1:0] cfg_first, cfg_last;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              m_valid, m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_last;
    logic              busy, done, err;
    logic [2:0]        dbg_state;

    array_ram_dumper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_first(cfg_first), .cfg_last(cfg_last),
        .ram_re(ram_re), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_addr(m_addr), .m_last(m_last), .busy(busy), .done(done),
        .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model (1-cycle read latency) ----------------
    logic [DATA_W-1:0] mem [4096];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = DATA_W'(i * 3);
        ram_rdata = '0;
    end
    always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_addr];

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    bit            exp_done_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_beats  = 0;
    int n_re     = 0;
    int n_lasts  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_dump(input int f, input int l);
        for (int a = f; a <= l; a++)
            exp_q.push_back({(a == l), ADDR_W'(a), DATA_W'(a * 3)});
    endtask

    // ---------------- monitor ----------------
    logic              prev_stall = 1'b0;
    logic [BW-1:0]     prev_beat;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && m_valid)
                check("stall_stable", {m_last, m_addr, m_data}, prev_beat);
            if (ram_re) n_re++;
            if (m_valid && m_ready) begin
                n_beats++;
                if (m_last) n_lasts++;
                if (exp_q.size() == 0) check("beat_unexpected", {m_last, m_addr, m_data}, '0);
                else check("beat", {m_last, m_addr, m_data}, exp_q.pop_front());
            end
            if (done) begin
                if (exp_done_q.size() == 0) check("done_unexpected", 1, 0);
                else check("done_err", err, exp_done_q.pop_front());
            end
            if (err && !done) check("err_without_done", 1, 0);
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_addr, m_data};
        end
    end

    // ---------------- driver tasks ----------------
    bit ready_pat [16] = '{0,0,0,0,0,1,0,1,1,0,0,1,0,1,1,1};

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int f, input int l);
        cfg_first = ADDR_W'(f);
        cfg_last  = ADDR_W'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int max_cycles, input bit use_pat);
        bit seen = 0;
        int gaps = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            m_ready = use_pat ? ready_pat[i % 16] : 1'b1;
            tick();
            if (done) seen = 1;
            else if (!busy) gaps++;
        end
        check("done_seen", seen, 1);
        check("busy_throughout", gaps, 0);
        m_ready = 1'b1;
    endtask

    task automatic wait_beats(input int base, input int n);
        for (int i = 0; i < 400 && (n_beats - base) < n; i++) tick();
        check("beats_reached", (n_beats - base) >= n, 1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !m_valid; i++) tick();
        check("valid_reached", m_valid, 1);
    endtask

    // ---------------- stimulus ----------------
    int base_beats, base_re;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
        cfg_first = '0; cfg_last = '0;
        tick(); tick();
        check("reset_outputs", {ram_re, m_valid, m_last, busy, done, err, dbg_state}, '0);
        check("reset_payload", {m_data, m_addr, ram_addr}, '0);
        rst_n = 1'b1;
        tick();

        // Single-word range: latency and m_last.
        push_dump(7, 7); exp_done_q.push_back(1'b0);
        pulse_start(7, 7);
        check("t3_c1_ram_re", {ram_re, ram_addr}, {1'b1, 12'd7});
        tick();
        check("t3_c2_no_valid", m_valid, 0);
        tick();
        check("t3_c3_beat", {m_valid, m_last, m_addr, m_data}, {1'b1, 1'b1, 12'd7, 32'd21});
        tick();
        check("t3_c4_done", {done, err, m_valid, busy}, 4'b1001);
        tick();
        check("t3_c5_idle", {busy, done}, 2'b00);
        check("t3_drained", exp_q.size(), 0);

        // Empty range: error path without any read.
        base_re = n_re;
        exp_done_q.push_back(1'b1);
        pulse_start(20, 5);
        check("t4_c1_done_err", {done, err, busy, ram_re, m_valid}, 5'b11100);
        tick();
        check("t4_c2_idle", {done, err, busy}, 3'b000);
        tick();
        check("t4_no_reads", n_re - base_re, 0);

        // Backpressure with stalls of varying length.
        push_dump(10, 13); exp_done_q.push_back(1'b0);
        pulse_start(10, 13);
        run_until_done(300, 1'b1);
        check("t2_drained", exp_q.size(), 0);
        tick();

        // Full-depth dump with m_ready held high.
        base_beats = n_beats; base_re = n_re; n_lasts = 0;
        push_dump(0, 4095); exp_done_q.push_back(1'b0);
        pulse_start(0, 4095);
        run_until_done(13000, 1'b0);
        tick(); tick();
        check("t1_beats", n_beats - base_beats, 4096);
        check("t1_reads", n_re - base_re, 4096);
        check("t1_one_last", n_lasts, 1);
        check("t1_drained", exp_q.size(), 0);
        check("t1_idle", busy, 0);

        // Abort during a stalled beat, then a fresh short dump.
        base_beats = n_beats;
        push_dump(0, 100);
        pulse_start(0, 100);
        wait_beats(base_beats, 40);
        m_ready = 1'b0;
        wait_valid();
        check("t5_stalled_addr", m_addr, 40);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_after_abort", {m_valid, busy, ram_re, done, dbg_state}, '0);
        exp_q.delete();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        // start and abort together in IDLE: request dropped.
        abort = 1'b1;
        pulse_start(3, 9);
        abort = 1'b0;
        check("t5_abort_wins", {busy, ram_re}, 2'b00);
        tick();
        base_beats = n_beats;
        push_dump(0, 1); exp_done_q.push_back(1'b0);
        pulse_start(0, 1);
        run_until_done(50, 1'b0);
        tick();
        check("t5_two_beats", n_beats - base_beats, 2);

        // Restart while busy is ignored; async reset mid-dump.
        base_beats = n_beats;
        push_dump(50, 60);
        pulse_start(50, 60);
        tick(); tick();
        pulse_start(200, 210);
        wait_beats(base_beats, 5);
        m_ready = 1'b0;
        wait_valid();
        check("t6_stalled_addr", {m_addr, m_data}, {12'd55, 32'd165});
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_reset", {ram_re, m_valid, m_last, busy, done, err, dbg_state}, '0);
        check("t6_reset_payload", {m_data, m_addr, ram_addr}, '0);
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        tick(); tick();
        check("t6_idle_after_reset", {busy, m_valid, ram_re, done}, '0);
        check("t6_no_pending_done", exp_done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
